// File: rtl/prog_mem_if.sv
// Fetch/load bus of the program memory: combinational read port plus a synchronous write port.
// The master side is the fetch/loader; the slave side is the memory itself.
interface prog_mem_if #(
  parameter int AW = 8,
  parameter int DW = 17
);
  logic [AW-1:0] addr;
  logic [DW-1:0] instr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output addr, wr_en, wr_addr, wr_data,
    input  instr
  );

  modport slave (
    input  addr, wr_en, wr_addr, wr_data,
    output instr
  );
endinterface

// File: rtl/prog_mem.sv
// Program memory: 2**AW x DW register array with combinational fetch, synchronous write,
// and an asynchronous reset that reloads the boot image.
module prog_mem #(
  parameter int AW = 8,
  parameter int DW = 17
) (
  input  logic       clk,
  input  logic       rst,
  prog_mem_if.slave  bus
);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Boot program lives in the first eight words; everything above is zero.
  function automatic logic [DW-1:0] boot_word(input int unsigned a);
    case (a)
      0:       boot_word = DW'(17'h0A001);
      1:       boot_word = DW'(17'h0A102);
      2:       boot_word = DW'(17'h10010);
      3:       boot_word = DW'(17'h18001);
      4:       boot_word = DW'(17'h04020);
      5:       boot_word = DW'(17'h0C103);
      6:       boot_word = DW'(17'h1C005);
      7:       boot_word = DW'(17'h1F000);
      default: boot_word = '0;
    endcase
  endfunction

  // Reset has priority, so a write landing on an edge while rst is high is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= boot_word(i);
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // No write-through bypass: a same-address write shows up only after the edge.
  assign bus.instr = mem[bus.addr];
endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: boot image, writes, read-during-write, async reset, full sweep.
module tb_prog_mem;
  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;

  prog_mem_if #(.AW(8), .DW(17)) bus ();

  prog_mem #(.AW(8), .DW(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  logic [16:0] boot [8];
  logic [16:0] exp_w;

  initial begin
    boot[0] = 17'h0A001; boot[1] = 17'h0A102; boot[2] = 17'h10010; boot[3] = 17'h18001;
    boot[4] = 17'h04020; boot[5] = 17'h0C103; boot[6] = 17'h1C005; boot[7] = 17'h1F000;

    rst         = 1'b1;
    bus.addr    = 8'd0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 8'd0;
    bus.wr_data = '0;
    #3;
    chk("reset_addr0", bus.instr, 17'h0A001);

    @(negedge clk);
    rst = 1'b0;

    // Boot fetch sweep, 1 ns per address
    for (int i = 0; i < 8; i++) begin
      bus.addr = 8'(i);
      #1;
      chk($sformatf("boot[%0d]", i), bus.instr, boot[i]);
    end

    bus.addr = 8'd8;   #1; chk("unused_8",   bus.instr, 17'h00000);
    bus.addr = 8'd100; #1; chk("unused_100", bus.instr, 17'h00000);
    bus.addr = 8'd255; #1; chk("unused_255", bus.instr, 17'h00000);

    // Write then read
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 8'h40; bus.wr_data = 17'h1ABCD;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.addr = 8'h40; #1; chk("wr_40",      bus.instr, 17'h1ABCD);
    bus.addr = 8'h41; #1; chk("wr_41_zero", bus.instr, 17'h00000);

    // Read-during-write on address 3
    @(negedge clk);
    bus.addr = 8'd3; bus.wr_addr = 8'd3; bus.wr_data = 17'h00055; bus.wr_en = 1'b1;
    #1; chk("rdw_before", bus.instr, 17'h18001);
    @(posedge clk); #1;
    chk("rdw_after", bus.instr, 17'h00055);
    bus.wr_en = 1'b0; bus.wr_data = 17'h1FFFF;
    @(posedge clk); #1;
    chk("rdw_hold", bus.instr, 17'h00055);

    // Async reset pulse between edges
    @(negedge clk); #2;
    rst = 1'b1;
    #1; chk("arst_addr3",  bus.instr, 17'h18001);
    bus.addr = 8'h40;
    #1; chk("arst_addr40", bus.instr, 17'h00000);
    bus.wr_en = 1'b1; bus.wr_addr = 8'h40; bus.wr_data = 17'h12345;
    @(posedge clk); #1;
    chk("arst_wr_drop", bus.instr, 17'h00000);
    @(negedge clk);
    bus.wr_en = 1'b0;
    rst = 1'b0;
    #1; chk("post_rst_40", bus.instr, 17'h00000);
    bus.addr = 8'd3;
    #1; chk("post_rst_3",  bus.instr, 17'h18001);

    // Full-range write then readback
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'(i);
      bus.wr_data = 17'(i) ^ 17'h15A5A;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.addr = 8'(i);
      exp_w    = 17'(i) ^ 17'h15A5A;
      #1;
      chk($sformatf("full[%0d]", i), bus.instr, exp_w);
    end
    bus.addr = 8'd0;
    #1; chk("msb_kept", {16'b0, bus.instr[16]}, 17'h00001);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
- Program (instruction) memory for the microprocessor: 256 words x 17 bits, addressed by the 8-bit program counter.
- Read is combinational, so the fetch stage gets the instruction in the same cycle the PC is presented.
- A synchronous write port loads or patches programs.
- Asynchronous reset restores a fixed boot image.

Parameters:
- AW, 8, address width; depth = 2**AW = 256 words.
- DW, 17, instruction word width.

Ports:
- clk  input  1  system clock; all writes on its rising edge.
- rst  input  1  asynchronous, active-high reset; restores boot image.
- addr  input  AW  read address (program counter).
- instr  output  DW  instruction word at addr.
- wr_en  input  1  write enable, sampled on rising clk.
- wr_addr  input  AW  write address.
- wr_data  input  DW  word to write.

Behaviour:
- Storage: 256 x 17-bit register array mem[0..255].
- Read path:
  - instr = mem[addr], purely combinational, zero-cycle latency.
  - A change on addr updates instr within the same cycle, with no clock required.
  - All 256 addresses are valid; there is no out-of-range case.
- Reset:
  - While rst=1, independent of clk, the memory holds the boot image and writes are ignored.
  - instr reflects the boot image at the current addr during and after reset.
- Boot image:
  - mem[0]=17'h0A001
  - mem[1]=17'h0A102
  - mem[2]=17'h10010
  - mem[3]=17'h18001
  - mem[4]=17'h04020
  - mem[5]=17'h0C103
  - mem[6]=17'h1C005
  - mem[7]=17'h1F000
  - mem[8..255]=17'h00000
- Write:
  - On a rising clk with rst=0 and wr_en=1: mem[wr_addr] <= wr_data.
  - With wr_en=0, memory is unchanged.
- Read-during-write, same address:
  - Before the edge, instr shows the old word.
  - From the edge onward, it shows wr_data; there is no write-through bypass.
- Reset mid-operation:
  - Asserting rst asynchronously discards all prior writes and restores the boot image immediately.
  - A write coinciding with the edge on which rst is high is dropped.
- Width rules: wr_data is stored as a full 17-bit word with no masking; instr is exactly DW bits.
- No other state, no handshake, no X on instr after reset.

Test Plan:
- Boot fetch:
  - Stimulus: assert rst, release; sweep addr 0..7 at 1 ns steps with no clock edges.
  - Required response: instr = 0A001, 0A102, 10010, 18001, 04020, 0C103, 1C005, 1F000 in the same time step as each addr change.
- Unused region: addr=8, 100, 255 -> instr=17'h00000.
- Write then read:
  - Stimulus: wr_en=1, wr_addr=8'h40, wr_data=17'h1ABCD, one clk edge; then addr=8'h40.
  - Required response: instr=17'h1ABCD; addr=8'h41 still reads 0.
- Read-during-write:
  - Stimulus: addr=3, wr_addr=3, wr_data=17'h00055, wr_en=1.
  - Required response: instr=18001 before the edge, 00055 after it.
  - Then with wr_en=0 and wr_data changed, instr is unchanged.
- Async reset mid-run:
  - Stimulus: after the writes above, pulse rst between clock edges.
  - Required response: instr immediately returns to the boot image (addr=3 -> 18001, addr=8'h40 -> 0).
  - A write with wr_en=1 while rst=1 has no effect.
- Full-range write/readback:
  - Stimulus: write mem[i]=i^17'h15A5A for i=0..255; read all 256.
  - Required response: every word matches; MSB (bit 16) is preserved.
